// File: rtl/seg7_reader.sv
// Recovers digits from a live active-low gfedcba segment bus, debounces them and packs them into
// a BCD frame with a valid/ready handoff. Define SEG7_READER_HEX_EN to also accept A-F glyphs.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_invalid,
    output logic                    busy
);

    localparam logic [6:0] Blank  = 7'h7f;
    localparam logic [7:0] Stable = 8'(STABLE_CYCLES);
    localparam logic [3:0] Num    = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {StGap, StArm, StHold, StFull} state_e;

    state_e                  state_q;
    logic [6:0]              seg_q;
    logic [7:0]              cnt_q;
    logic [3:0]              digit_cnt_q;
    logic [4*NUM_DIGITS-1:0] acc_q;
    logic [4*NUM_DIGITS-1:0] acc_next;
    logic [4:0]              dec;
    logic [3:0]              cnt_inc;
    logic                    is_blank;
    logic                    take;

    // Returns {valid, digit}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0011000: r = 5'h19;
`ifdef SEG7_READER_HEX_EN
            7'b0001000: r = 5'h1a;
            7'b0000011: r = 5'h1b;
            7'b1000110: r = 5'h1c;
            7'b0100001: r = 5'h1d;
            7'b0000110: r = 5'h1e;
            7'b0001110: r = 5'h1f;
`endif
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    assign dec      = decode(seg_q);
    assign is_blank = (seg_q == Blank);
    assign cnt_inc  = digit_cnt_q + 4'd1;
    // GAP is included so a one-cycle debounce still accepts on the first stable cycle.
    assign take     = !is_blank && (cnt_q == Stable) && (state_q == StGap || state_q == StArm);

    if (NUM_DIGITS == 1) begin : g_one
        assign acc_next = dec[3:0];
    end else begin : g_many
        assign acc_next = {acc_q[4*NUM_DIGITS-5:0], dec[3:0]};
    end

    assign bcd_out = acc_q;
    assign busy    = (state_q != StGap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGap;
            seg_q       <= Blank;
            cnt_q       <= 8'd1;
            digit_cnt_q <= 4'd0;
            acc_q       <= '0;
            out_valid   <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            seg_q       <= seg;
            err_invalid <= 1'b0;
            if (seg != seg_q) begin
                cnt_q <= 8'd1;
            end else if (cnt_q < Stable) begin
                cnt_q <= cnt_q + 8'd1;
            end

            unique case (state_q)
                StGap:  if (!is_blank) state_q <= StArm;
                StArm:  if (is_blank) state_q <= StGap;
                StHold: if (is_blank) state_q <= StGap;
                StFull: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        digit_cnt_q <= 4'd0;
                        out_valid   <= 1'b0;
                        state_q     <= StHold;
                    end
                end
                default: state_q <= StGap;
            endcase

            if (take) begin
                if (dec[4]) begin
                    acc_q       <= acc_next;
                    digit_cnt_q <= cnt_inc;
                    if (cnt_inc == Num) begin
                        out_valid <= 1'b1;
                        state_q   <= StFull;
                    end else begin
                        state_q <= StHold;
                    end
                end else begin
                    err_invalid <= 1'b1;
                    state_q     <= StHold;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with default parameters; frames and error pulses are logged
// at the falling edge and compared against hand-computed values.
module tb_seg7_reader;

`ifdef SEG7_READER_HEX_EN
    localparam bit HexEn = 1'b1;
`else
    localparam bit HexEn = 1'b0;
`endif
    localparam logic [6:0] Blank = 7'h7f;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [15:0] bcd_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_invalid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int nframes = 0;
    int nerr    = 0;
    int nvalid  = 0;
    logic [15:0] frames [0:63];
    logic [6:0]  pat [0:9];

    seg7_reader #(
        .STABLE_CYCLES(4),
        .NUM_DIGITS   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .bcd_out    (bcd_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_invalid(err_invalid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_invalid) nerr++;
        if (out_valid) nvalid++;
        if (out_valid && out_ready) begin
            if (nframes < 64) frames[nframes] = bcd_out;
            nframes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] p, input int hold, input int gap);
        seg = p;
        repeat (hold) tick();
        seg = Blank;
        repeat (gap) tick();
    endtask

    task automatic show(input int d);
        present(pat[d], 6, 3);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] exp);
        check({tag, "_count"}, 32'(nframes - base), 32'd1);
        check({tag, "_value"}, 32'(frames[base]), 32'(exp));
    endtask

    initial begin
        int fb;
        int eb;
        int vb;
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0011000;

        rst = 1'b1;
        seg = Blank;
        out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_err", 32'(err_invalid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (2) tick();

        // Digit sequence 1,2,3,4; the last one is traced cycle by cycle.
        fb = nframes; eb = nerr; vb = nvalid;
        show(1); show(2); show(3);
        seg = pat[4];
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) seg = Blank;
            check("seq_valid_timing", 32'(out_valid), 32'(k == 5));
            if (k == 5) check("seq_bcd", 32'(bcd_out), 32'h1234);
        end
        check_frame("seq_frame", fb, 16'h1234);
        check("seq_valid_width", 32'(nvalid - vb), 32'd1);
        check("seq_no_err", 32'(nerr - eb), 32'd0);

        // Short glitch of '1' must not be recorded.
        fb = nframes; eb = nerr;
        present(pat[1], 3, 0);
        show(2); show(5); show(6); show(7);
        check_frame("glitch_frame", fb, 16'h2567);
        check("glitch_no_err", 32'(nerr - eb), 32'd0);

        // Invalid pattern: one-cycle error pulse at t+5.
        fb = nframes; eb = nerr;
        seg = 7'b0010000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) seg = Blank;
            check("inv_err_timing", 32'(err_invalid), 32'(k == 5));
        end
        check("inv_err_count", 32'(nerr - eb), 32'd1);
        eb = nerr;
        present(7'b0001000, 6, 3);
        check("hexA_err", 32'(nerr - eb), HexEn ? 32'd0 : 32'd1);
        show(8); show(9); show(0);
        if (!HexEn) show(1);
        check_frame("inv_frame", fb, HexEn ? 16'ha890 : 16'h8901);

        // Backpressure: frame holds while extra digits are ignored.
        out_ready = 1'b0;
        fb = nframes;
        show(4); show(3); show(2); show(1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_bcd", 32'(bcd_out), 32'h4321);
        show(5); show(6); show(7); show(8); show(9);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_bcd_frozen", 32'(bcd_out), 32'h4321);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_no_xfer", 32'(nframes - fb), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check_frame("bp_frame", fb, 16'h4321);
        repeat (3) tick();
        out_ready = 1'b1;
        fb = nframes;
        show(1); show(2); show(3); show(4);
        check_frame("bp_next_frame", fb, 16'h1234);

        // Long hold of '3' counts once; a blank then re-hold counts again.
        fb = nframes;
        present(pat[3], 40, 3);
        show(3); show(7); show(7);
        check_frame("repeat_frame", fb, 16'h3377);

        // Mid-frame reset discards the partial frame.
        fb = nframes;
        show(1); show(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_bcd", 32'(bcd_out), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_err", 32'(err_invalid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        tick();
        show(5); show(6); show(7); show(8);
        check_frame("mrst_frame", fb, 16'h5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
